// File: rtl/sum_accumulator_if.sv
// -----------------------------------------------------------------------------
// sum_accumulator_if
// Groups the sample-input and byte-output handshakes of sum_accumulator.
//   sum_in/carry_in/in_valid/in_ready : 9-bit sample stream from the adder
//   out_data/out_valid/out_ready/out_last/out_ovf : 2-byte result stream
//   count : samples accepted in the current frame
// master : the side that produces samples and consumes result bytes
// slave  : the accumulator itself
// -----------------------------------------------------------------------------
interface sum_accumulator_if;
   logic [7:0] sum_in;
   logic       carry_in;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       out_ovf;
   logic [7:0] count;

   modport master (
      output sum_in, carry_in, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last, out_ovf, count
   );

   modport slave (
      input  sum_in, carry_in, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last, out_ovf, count
   );
endinterface

// File: rtl/sum_accumulator.sv
// -----------------------------------------------------------------------------
// sum_accumulator
// Accumulates N_SAMPLES 9-bit adder results ({carry, sum}) into a 16-bit
// total, then streams the total out low byte first, high byte second.
// A sticky flag reports whether the 16-bit total wrapped within the frame.
// Ports:
//   clk   : single clock, rising edge
//   rst   : synchronous active-high reset (priority over clear)
//   clear : synchronous frame abort, same effect as rst
//   bus   : sample/result handshakes (see sum_accumulator_if)
// -----------------------------------------------------------------------------
module sum_accumulator #(
   parameter int N_SAMPLES = 4
) (
   input logic              clk,
   input logic              rst,
   input logic              clear,
   sum_accumulator_if.slave bus
);

   typedef enum logic [1:0] {
      ACCUM   = 2'b00,
      SEND_LO = 2'b01,
      SEND_HI = 2'b10
   } state_t;

   localparam logic [7:0] LAST_COUNT = 8'(N_SAMPLES - 1);

   state_t      state_r;
   state_t      state_s;
   logic [15:0] acc_r;
   logic [15:0] acc_s;
   logic        ovf_r;
   logic        ovf_s;
   logic [7:0]  count_r;
   logic [7:0]  count_s;
   logic [16:0] sum_s;

   logic        in_ready_s;
   logic        out_valid_s;
   logic [7:0]  out_data_s;
   logic        out_last_s;
   logic        out_ovf_s;

   // Output decode from registered state; rst/clear gate only in_ready so an
   // aborting cycle can never also accept a sample.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      out_data_s  = 8'h00;
      out_last_s  = 1'b0;
      out_ovf_s   = 1'b0;
      case (state_r)
         ACCUM: begin
            in_ready_s = !rst && !clear;
         end
         SEND_LO: begin
            out_valid_s = 1'b1;
            out_data_s  = acc_r[7:0];
            out_ovf_s   = ovf_r;
         end
         SEND_HI: begin
            out_valid_s = 1'b1;
            out_data_s  = acc_r[15:8];
            out_last_s  = 1'b1;
            out_ovf_s   = ovf_r;
         end
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // 17-bit sum so the carry out of bit 15 feeds the sticky wrap flag.
   always_comb begin
      sum_s = {1'b0, acc_r} + {8'h00, bus.carry_in, bus.sum_in};
   end

   // Next-state and datapath update.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      ovf_s   = ovf_r;
      count_s = count_r;
      case (state_r)
         ACCUM: begin
            if (bus.in_valid && in_ready_s) begin
               acc_s   = sum_s[15:0];
               ovf_s   = ovf_r | sum_s[16];
               count_s = count_r + 8'd1;
               if (count_r == LAST_COUNT) begin
                  state_s = SEND_LO;
               end else begin
                  state_s = ACCUM;
               end
            end else begin
               state_s = ACCUM;
            end
         end
         SEND_LO: begin
            if (bus.out_ready) begin
               state_s = SEND_HI;
            end else begin
               state_s = SEND_LO;
            end
         end
         SEND_HI: begin
            if (bus.out_ready) begin
               state_s = ACCUM;
               acc_s   = 16'h0000;
               ovf_s   = 1'b0;
               count_s = 8'h00;
            end else begin
               state_s = SEND_HI;
            end
         end
         default: begin
            // Unreachable encoding: recover to an empty frame.
            state_s = ACCUM;
            acc_s   = 16'h0000;
            ovf_s   = 1'b0;
            count_s = 8'h00;
         end
      endcase
   end

   // State and datapath registers; rst and clear both abort the frame.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         state_r <= ACCUM;
         acc_r   <= 16'h0000;
         ovf_r   <= 1'b0;
         count_r <= 8'h00;
      end else begin
         state_r <= state_s;
         acc_r   <= acc_s;
         ovf_r   <= ovf_s;
         count_r <= count_s;
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.out_data  = out_data_s;
   assign bus.out_last  = out_last_s;
   assign bus.out_ovf   = out_ovf_s;
   assign bus.count     = count_r;

endmodule

// File: tb/tb_sum_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sum_accumulator
// Scoreboard bench: expected result bytes are queued when a frame's samples
// are driven and checked as the DUT hands each byte over. Two instances:
// N_SAMPLES = 4 and N_SAMPLES = 200.
// -----------------------------------------------------------------------------
module tb_sum_accumulator;

   logic clk = 1'b0;
   logic rst;
   logic clear;

   sum_accumulator_if bus4 ();
   sum_accumulator_if bus200 ();

   sum_accumulator #(.N_SAMPLES(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus4)
   );

   sum_accumulator #(.N_SAMPLES(200)) u_dut200 (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .bus   (bus200)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // {ovf, last, data}
   logic [9:0] q4[$];
   logic [9:0] q200[$];
   logic [10:0] e4;
   logic [10:0] e200;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard side: a byte transfers at the next rising edge.
   always @(negedge clk) begin
      if (!rst && !clear && bus4.out_valid && bus4.out_ready) begin
         e4 = (q4.size() > 0) ? {1'b1, q4.pop_front()} : 11'h000;
         check_eq("b4_expected", {31'd0, e4[10]}, 32'd1);
         check_eq("b4_data", {24'd0, bus4.out_data}, {24'd0, e4[7:0]});
         check_eq("b4_last", {31'd0, bus4.out_last}, {31'd0, e4[8]});
         check_eq("b4_ovf", {31'd0, bus4.out_ovf}, {31'd0, e4[9]});
      end
      if (!rst && !clear && bus200.out_valid && bus200.out_ready) begin
         e200 = (q200.size() > 0) ? {1'b1, q200.pop_front()} : 11'h000;
         check_eq("b200_expected", {31'd0, e200[10]}, 32'd1);
         check_eq("b200_data", {24'd0, bus200.out_data}, {24'd0, e200[7:0]});
         check_eq("b200_last", {31'd0, bus200.out_last}, {31'd0, e200[8]});
         check_eq("b200_ovf", {31'd0, bus200.out_ovf}, {31'd0, e200[9]});
      end
   end

   // Queue both bytes of a frame whose true (unwrapped) sum is total.
   task automatic expect_frame(input bit big, input int total);
      logic        ovf;
      logic [15:0] t;
      ovf = (total > 65535);
      t   = 16'(total % 65536);
      if (big) begin
         q200.push_back({ovf, 1'b0, t[7:0]});
         q200.push_back({ovf, 1'b1, t[15:8]});
      end else begin
         q4.push_back({ovf, 1'b0, t[7:0]});
         q4.push_back({ovf, 1'b1, t[15:8]});
      end
   endtask

   // Present one sample and hold it until accepted (bounded).
   task automatic put_sample(input bit big, input logic c, input logic [7:0] s);
      int   waits;
      logic rdy;
      waits = 0;
      if (big) begin
         bus200.carry_in = c; bus200.sum_in = s; bus200.in_valid = 1'b1;
      end else begin
         bus4.carry_in = c; bus4.sum_in = s; bus4.in_valid = 1'b1;
      end
      @(negedge clk);
      rdy = big ? bus200.in_ready : bus4.in_ready;
      while (!rdy && waits < 50) begin
         waits++;
         @(negedge clk);
         rdy = big ? bus200.in_ready : bus4.in_ready;
      end
      check_eq("accept", {31'd0, rdy}, 32'd1);
      @(posedge clk);
      #1;
      if (big) bus200.in_valid = 1'b0;
      else     bus4.in_valid = 1'b0;
   endtask

   // Wait for the scoreboard to empty, then step past the final handshake.
   task automatic drain(input bit big);
      int waits;
      waits = 0;
      while ((big ? q200.size() : q4.size()) != 0 && waits < 600) begin
         waits++;
         @(negedge clk);
      end
      check_eq("drain", big ? q200.size() : q4.size(), 32'd0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      clear = 1'b0;
      bus4.sum_in = 8'h00;   bus4.carry_in = 1'b0;   bus4.in_valid = 1'b0;   bus4.out_ready = 1'b0;
      bus200.sum_in = 8'h00; bus200.carry_in = 1'b0; bus200.in_valid = 1'b0; bus200.out_ready = 1'b0;

      // Reset
      @(posedge clk);
      @(negedge clk);
      check_eq("rst_in_ready_low", {31'd0, bus4.in_ready}, 32'd0);
      check_eq("rst_out_valid_low", {31'd0, bus4.out_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset_in_ready", {31'd0, bus4.in_ready}, 32'd1);
      check_eq("reset_out_valid", {31'd0, bus4.out_valid}, 32'd0);
      check_eq("reset_out_data", {24'd0, bus4.out_data}, 32'h00);
      check_eq("reset_out_last", {31'd0, bus4.out_last}, 32'd0);
      check_eq("reset_out_ovf", {31'd0, bus4.out_ovf}, 32'd0);
      check_eq("reset_count", {24'd0, bus4.count}, 32'd0);
      @(posedge clk);
      #1;

      // Basic frame: 0xFF + 0x100 + 0x1FF + 0x001 = 0x3FF
      bus4.out_ready = 1'b1;
      expect_frame(1'b0, 32'h3FF);
      put_sample(1'b0, 1'b0, 8'hFF);
      check_eq("count_after_1", {24'd0, bus4.count}, 32'd1);
      put_sample(1'b0, 1'b1, 8'h00);
      put_sample(1'b0, 1'b1, 8'hFF);
      put_sample(1'b0, 1'b0, 8'h01);
      check_eq("basic_latency_valid", {31'd0, bus4.out_valid}, 32'd1);
      check_eq("basic_latency_data", {24'd0, bus4.out_data}, 32'hFF);
      check_eq("basic_send_count", {24'd0, bus4.count}, 32'd4);
      drain(1'b0);
      check_eq("b2b_in_ready", {31'd0, bus4.in_ready}, 32'd1);
      check_eq("b2b_count", {24'd0, bus4.count}, 32'd0);

      // Backpressure in SEND_LO with in_valid held high
      bus4.out_ready = 1'b0;
      expect_frame(1'b0, 32'h3FF);
      put_sample(1'b0, 1'b0, 8'hFF);
      put_sample(1'b0, 1'b1, 8'h00);
      put_sample(1'b0, 1'b1, 8'hFF);
      put_sample(1'b0, 1'b0, 8'h01);
      bus4.in_valid = 1'b1;
      bus4.sum_in = 8'h55;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("bp_out_data", {24'd0, bus4.out_data}, 32'hFF);
         check_eq("bp_out_last", {31'd0, bus4.out_last}, 32'd0);
         check_eq("bp_in_ready", {31'd0, bus4.in_ready}, 32'd0);
         check_eq("bp_count", {24'd0, bus4.count}, 32'd4);
      end
      @(posedge clk);
      #1;
      bus4.in_valid = 1'b0;
      bus4.out_ready = 1'b1;
      drain(1'b0);
      check_eq("bp_after_count", {24'd0, bus4.count}, 32'd0);

      // Overflow: 200 * 0x1FF = 102200 -> 0x8F38 with wrap
      bus200.out_ready = 1'b1;
      expect_frame(1'b1, 200 * 511);
      for (int i = 0; i < 200; i++) put_sample(1'b1, 1'b1, 8'hFF);
      drain(1'b1);

      // Clear mid-frame
      put_sample(1'b0, 1'b0, 8'h05);
      put_sample(1'b0, 1'b0, 8'h05);
      check_eq("pre_clear_count", {24'd0, bus4.count}, 32'd2);
      clear = 1'b1;
      @(negedge clk);
      check_eq("clear_in_ready", {31'd0, bus4.in_ready}, 32'd0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      check_eq("clear_count", {24'd0, bus4.count}, 32'd0);
      expect_frame(1'b0, 32'h40);
      for (int i = 0; i < 4; i++) put_sample(1'b0, 1'b0, 8'h10);
      drain(1'b0);

      // Reset while the high byte is pending: only the low byte transfers
      q4.push_back({1'b0, 1'b0, 8'h88});
      for (int i = 0; i < 4; i++) put_sample(1'b0, 1'b0, 8'h22);
      @(posedge clk);
      #1;
      bus4.out_ready = 1'b0;
      check_eq("hi_out_valid", {31'd0, bus4.out_valid}, 32'd1);
      check_eq("hi_out_last", {31'd0, bus4.out_last}, 32'd1);
      check_eq("hi_out_data", {24'd0, bus4.out_data}, 32'h00);
      check_eq("lo_consumed", q4.size(), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_eq("rst_hi_out_valid", {31'd0, bus4.out_valid}, 32'd0);
      check_eq("rst_hi_out_data", {24'd0, bus4.out_data}, 32'h00);
      rst = 1'b0;
      @(negedge clk);
      check_eq("rst_hi_in_ready", {31'd0, bus4.in_ready}, 32'd1);
      check_eq("rst_hi_count", {24'd0, bus4.count}, 32'd0);
      @(posedge clk);
      #1;
      bus4.out_ready = 1'b1;
      expect_frame(1'b0, 4 * 32'h180);
      for (int i = 0; i < 4; i++) put_sample(1'b0, 1'b1, 8'h80);
      drain(1'b0);

      check_eq("q4_empty", q4.size(), 32'd0);
      check_eq("q200_empty", q200.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
